// File: rtl/core_v_mcu_pkg.sv
// rtl/core_v_mcu_pkg.sv - shared register-bus types, peripheral map and demux constants
package core_v_mcu_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_RESP
  } demux_state_e;

  localparam int unsigned NumPeriphs     = 4;
  localparam int unsigned SocCtrlIdx     = 0;
  localparam int unsigned BootRomIdx     = 1;
  localparam int unsigned FastIntrCtrlIdx = 2;
  localparam int unsigned UartIdx        = 3;

  localparam int unsigned RegTimeoutCycles = 255;

  // Listed from the highest array position down to position 0.
  localparam rule_t [NumPeriphs-1:0] PeriphAddrMap = '{
    '{idx: 32'(UartIdx),         start_addr: 32'h1000_3000, end_addr: 32'h1000_4000},
    '{idx: 32'(FastIntrCtrlIdx), start_addr: 32'h1000_2000, end_addr: 32'h1000_3000},
    '{idx: 32'(BootRomIdx),      start_addr: 32'h1000_1000, end_addr: 32'h1000_2000},
    '{idx: 32'(SocCtrlIdx),      start_addr: 32'h1000_0000, end_addr: 32'h1000_1000}
  };

endpackage

// File: rtl/reg_addr_decode.sv
// rtl/reg_addr_decode.sv - combinational priority address decoder over a rule map
module reg_addr_decode
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumSlaves = 4,
  parameter int unsigned SelW      = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
  parameter type         rule_t    = core_v_mcu_pkg::rule_t,
  parameter rule_t [NumSlaves-1:0] AddrMap = '0
) (
  input  logic [31:0]     addr_i,
  output logic [SelW-1:0] sel_o,
  output logic            hit_o
);

  // Walk from the highest position down so the lowest matching position is applied last.
  // A matching rule with an out-of-range idx claims the address as unmapped.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if ((addr_i >= AddrMap[i].start_addr) && (addr_i < AddrMap[i].end_addr)) begin
        hit_o = (AddrMap[i].idx < NumSlaves);
        sel_o = AddrMap[i].idx[SelW-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_reg_demux.sv
// rtl/periph_reg_demux.sv - registered register-bus demux with decode errors
// Optional per-transaction watchdog compiled in with PERIPH_REG_DEMUX_TIMEOUT_EN.
module periph_reg_demux
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumSlaves     = 4,
  parameter int unsigned TimeoutCycles = 255,
  parameter type         rule_t        = core_v_mcu_pkg::rule_t,
  parameter rule_t [NumSlaves-1:0] AddrMap = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  reg_req_t                   req_i,
  output reg_rsp_t                   rsp_o,
  output reg_req_t [NumSlaves-1:0]   slv_req_o,
  input  reg_rsp_t [NumSlaves-1:0]   slv_rsp_i,
  output logic                       decode_err_o,
  output logic                       timeout_o,
  output logic                       busy_o
);

  localparam int unsigned SelW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  demux_state_e    r_state, w_state_nxt;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic [3:0]      r_wstrb;
  logic            r_write, r_error, r_decode_err, r_timeout;
  logic [SelW-1:0] r_sel, w_sel;
  logic            w_hit, w_expire, w_fwd;
  reg_rsp_t        w_slv_rsp;

  reg_addr_decode #(
    .NumSlaves (NumSlaves),
    .SelW      (SelW),
    .rule_t    (rule_t),
    .AddrMap   (AddrMap)
  ) u_decode (
    .addr_i (req_i.addr),
    .sel_o  (w_sel),
    .hit_o  (w_hit)
  );

  assign w_slv_rsp = slv_rsp_i[r_sel];
  assign w_fwd     = (r_state == ST_FWD);

`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_cnt;

  // Held at zero outside FWD, so every forwarded transaction starts a fresh count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                r_cnt <= '0;
    else if (!w_fwd)            r_cnt <= '0;
    else if (!w_slv_rsp.ready)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_expire = (r_cnt == CntW'(TimeoutCycles));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_i.valid) w_state_nxt = w_hit ? ST_FWD : ST_RESP;
      ST_FWD:  if (w_slv_rsp.ready || w_expire) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_sel        <= '0;
      r_rdata      <= '0;
      r_error      <= 1'b0;
      r_decode_err <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_decode_err <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i.valid) begin
            r_addr  <= req_i.addr;
            r_write <= req_i.write;
            r_wdata <= req_i.wdata;
            r_wstrb <= req_i.wstrb;
            r_sel   <= w_sel;
            if (!w_hit) begin
              r_rdata      <= '0;
              r_error      <= 1'b1;
              r_decode_err <= 1'b1;
            end
          end
        end
        ST_FWD: begin
          // A slave answering on the expiry cycle still completes normally.
          if (w_slv_rsp.ready) begin
            r_rdata <= w_slv_rsp.rdata;
            r_error <= w_slv_rsp.error;
          end else if (w_expire) begin
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NumSlaves; g++) begin : g_port
    assign slv_req_o[g] = '{
      addr:  r_addr,
      write: r_write,
      wdata: r_wdata,
      wstrb: r_wstrb,
      valid: w_fwd && (r_sel == SelW'(g))
    };
  end

  assign rsp_o        = '{rdata: r_rdata, error: r_error, ready: (r_state == ST_RESP)};
  assign decode_err_o = r_decode_err;
  assign timeout_o    = r_timeout;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_periph_reg_demux.sv
// tb/tb_periph_reg_demux.sv - randomized self-checking bench for periph_reg_demux
module tb_periph_reg_demux;
  import core_v_mcu_pkg::*;

  localparam int TO_CYC = 8;
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Position 0 and 2 overlap at 0x1000_0000; position 1 names a non-existent slave.
  localparam rule_t [3:0] TB_MAP = '{
    '{idx: 32'd3, start_addr: 32'h1000_3000, end_addr: 32'h1000_4000},
    '{idx: 32'd2, start_addr: 32'h0FFF_0000, end_addr: 32'h1000_1000},
    '{idx: 32'd7, start_addr: 32'h1000_1000, end_addr: 32'h1000_2000},
    '{idx: 32'd0, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000}
  };

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  reg_req_t         req_i = '0;
  reg_rsp_t         rsp_o;
  reg_req_t [3:0]   slv_req_o;
  reg_rsp_t [3:0]   slv_rsp_i = '0;
  logic             decode_err_o, timeout_o, busy_o;
  int               total = 0;
  int               bad = 0;

  periph_reg_demux #(
    .NumSlaves     (4),
    .TimeoutCycles (TO_CYC),
    .rule_t        (rule_t),
    .AddrMap       (TB_MAP)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .rsp_o        (rsp_o),
    .slv_req_o    (slv_req_o),
    .slv_rsp_i    (slv_rsp_i),
    .decode_err_o (decode_err_o),
    .timeout_o    (timeout_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= TB_MAP[i].start_addr && a < TB_MAP[i].end_addr)
        return (TB_MAP[i].idx < 4) ? int'(TB_MAP[i].idx) : -1;
    return -1;
  endfunction

  function automatic logic [3:0] valid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = slv_req_o[i].valid;
    return v;
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] ws, input int lat, input logic [31:0] rd,
                         input logic er, input bit drop_early, input string name);
    int p, resp;
    bit to;
    logic [3:0] exp_v;
    logic [31:0] exp_rd;
    logic exp_er;
    p  = model_decode(addr);
    to = 1'b0;
    if (p < 0) resp = 1;
    else if (TO_EN && lat > TO_CYC) begin resp = TO_CYC + 2; to = 1'b1; end
    else resp = lat + 2;
    exp_rd = (p < 0 || to) ? 32'h0 : rd;
    exp_er = (p < 0 || to) ? 1'b1 : er;
    req_i = '{addr: addr, write: wr, wdata: wd, wstrb: ws, valid: 1'b1};
    slv_rsp_i = '0;
    for (int c = 1; c <= resp; c++) begin
      @(negedge clk_i);
      exp_v = (p >= 0 && c < resp) ? 4'(1 << p) : 4'b0;
      total++;
      if (valid_vec() !== exp_v) begin
        bad++; $display("FAIL %s valid c=%0d got=%b exp=%b", name, c, valid_vec(), exp_v);
      end
      total++;
      if ({rsp_o.ready, busy_o} !== {(c == resp), 1'b1}) begin
        bad++; $display("FAIL %s ready/busy c=%0d got=%b%b exp=%b1", name, c, rsp_o.ready, busy_o, (c == resp));
      end
      total++;
      if ({decode_err_o, timeout_o} !== {(c == resp) && (p < 0), (c == resp) && to}) begin
        bad++; $display("FAIL %s pulses c=%0d got=%b%b exp=%b%b", name, c, decode_err_o, timeout_o,
                        (c == resp) && (p < 0), (c == resp) && to);
      end
      if (c == 1 && p >= 0) begin
        total++;
        if ({slv_req_o[p].addr, slv_req_o[p].write, slv_req_o[p].wdata, slv_req_o[p].wstrb,
             slv_req_o[(p + 1) % 4].wdata} !== {addr, wr, wd, ws, wd}) begin
          bad++; $display("FAIL %s fields got=%h/%b/%h/%h exp=%h/%b/%h/%h", name, slv_req_o[p].addr,
                          slv_req_o[p].write, slv_req_o[p].wdata, slv_req_o[p].wstrb, addr, wr, wd, ws);
        end
      end
      if (c == resp) begin
        total++;
        if ({rsp_o.rdata, rsp_o.error} !== {exp_rd, exp_er}) begin
          bad++; $display("FAIL %s resp got=%h/%b exp=%h/%b", name, rsp_o.rdata, rsp_o.error, exp_rd, exp_er);
        end
      end
      if (drop_early || c == resp) req_i.valid = 1'b0;
      slv_rsp_i = '0;
      if (p >= 0 && c == lat + 1) slv_rsp_i[p] = '{rdata: rd, error: er, ready: 1'b1};
    end
    slv_rsp_i = '0;
    @(negedge clk_i);
    total++;
    if ({busy_o, rsp_o.ready, valid_vec()} !== 6'b0) begin
      bad++; $display("FAIL %s idle got busy=%b ready=%b valid=%b exp=0", name, busy_o, rsp_o.ready, valid_vec());
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if (slv_req_o !== '0) begin bad++; $display("FAIL reset slv_req got=%h exp=0", slv_req_o); end
    total++;
    if ({rsp_o, decode_err_o, timeout_o, busy_o} !== '0) begin
      bad++; $display("FAIL reset outputs got=%h/%b%b%b exp=0", rsp_o, decode_err_o, timeout_o, busy_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_directed;
    run_txn(32'h1000_0000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b0, 1'b0, "soc_read");
    run_txn(32'h1000_3008, 1'b1, 32'hDEAD_BEEF, 4'b1010, 5, 32'h1234_5678, 1'b0, 1'b0, "uart_write");
    run_txn(32'h1000_4000, 1'b0, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, "unmapped");
    run_txn(32'h1000_1004, 1'b1, 32'h5555_0000, 4'hF, 0, 32'h1, 1'b0, 1'b0, "idx7");
    run_txn(32'h0FFF_8000, 1'b0, 32'h0, 4'h0, 2, 32'hA5A5_0002, 1'b1, 1'b0, "port2_err");
    run_txn(32'h1000_0FFC, 1'b0, 32'h0, 4'h0, 1, 32'h0000_0FFC, 1'b0, 1'b0, "overlap_top");
    run_txn(32'h1000_2FFC, 1'b0, 32'h0, 4'h0, 0, 32'h1, 1'b0, 1'b0, "gap");
    run_txn(32'h1000_3FFC, 1'b0, 32'h0, 4'h0, 3, 32'h3333_0003, 1'b0, 1'b1, "drop_valid");
  endtask

  task automatic test_timeout;
    if (TO_EN) begin
      run_txn(32'h1000_3000, 1'b0, 32'h0, 4'h0, 1000, 32'h7777_7777, 1'b0, 1'b0, "timeout");
      run_txn(32'h1000_3004, 1'b0, 32'h0, 4'h0, TO_CYC, 32'h8888_0008, 1'b0, 1'b0, "ready_on_expiry");
    end
  endtask

  task automatic test_reset_mid;
    req_i = '{addr: 32'h1000_3010, write: 1'b1, wdata: 32'h1, wstrb: 4'h1, valid: 1'b1};
    slv_rsp_i = '0;
    @(negedge clk_i);
    total++;
    if (valid_vec() !== 4'b1000) begin bad++; $display("FAIL rst_mid fwd got=%b exp=1000", valid_vec()); end
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i.valid = 1'b0;
    @(negedge clk_i);
    total++;
    if ({valid_vec(), rsp_o.ready, busy_o} !== 6'b0) begin
      bad++; $display("FAIL rst_mid after got valid=%b ready=%b busy=%b exp=0", valid_vec(), rsp_o.ready, busy_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_txn(32'h1000_3010, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_random;
    logic [31:0] bases [6];
    logic [31:0] a;
    bases = '{32'h0FFF_F000, 32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000, 32'h1000_4000};
    for (int n = 0; n < 40; n++) begin
      a = bases[$urandom_range(0, 5)] + (32'($urandom_range(0, 32'hFFF)) & 32'hFFC);
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), int'($urandom_range(0, 6)),
              $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
